// File: rtl/flappy_pkg.sv
// Shared constants and types for the flappy renderer: screen geometry,
// object sizes, colours and the score-converter state encoding.
package flappy_pkg;

   localparam int H_ACTIVE      = 640;
   localparam int H_FRONT       = 16;
   localparam int H_SYNC        = 96;
   localparam int H_BACK        = 48;
   localparam int V_ACTIVE      = 480;
   localparam int V_FRONT       = 10;
   localparam int V_SYNC        = 2;
   localparam int V_BACK        = 33;

   localparam int BALL_X        = 213;
   localparam int BALL_WIDTH    = 10;
   localparam int BALL_HEIGHT   = 10;
   localparam int PILLAR_WIDTH  = 50;
   localparam int PILLAR_HEIGHT = 80;

   localparam logic [23:0] COL_BALL   = 24'hFFFFFF;
   localparam logic [23:0] COL_PILLAR = 24'h00C000;
   localparam logic [23:0] COL_SKY    = 24'h70C0FF;

   localparam logic [6:0] SEG_ZERO = 7'b1000000;

   typedef enum logic [1:0] {
      BCD_IDLE  = 2'd0,
      BCD_SHIFT = 2'd1,
      BCD_LOAD  = 2'd2
   } bcd_state_t;

   // Active-low gfedcba pattern for one decimal digit.
   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

endpackage

// File: rtl/flappy_render_seg7_bcd.sv
// Double-dabble binary-to-BCD converter driving three active-low
// seven-segment digits; a new start is only accepted while idle.
//
// state     | meaning
// BCD_IDLE  | waiting for start, digits hold last result
// BCD_SHIFT | 8 add-3/shift iterations, bit_cnt counts down
// BCD_LOAD  | drive hex0..2 from the finished digits
module seg7_bcd
   import flappy_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] bin,
   output logic [6:0] hex0,
   output logic [6:0] hex1,
   output logic [6:0] hex2,
   output logic       busy
);

   bcd_state_t  state;
   logic [7:0]  bin_sr;
   logic [11:0] bcd;
   logic [11:0] bcd_adj;
   logic [2:0]  bit_cnt;

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 3; i++) begin
         if (bcd[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   assign busy = (state != BCD_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= BCD_IDLE;
         bin_sr  <= '0;
         bcd     <= '0;
         bit_cnt <= '0;
         hex0    <= SEG_ZERO;
         hex1    <= SEG_ZERO;
         hex2    <= SEG_ZERO;
      end else begin
         case (state)
            BCD_IDLE: begin
               if (start) begin
                  bin_sr  <= bin;
                  bcd     <= '0;
                  bit_cnt <= 3'd7;
                  state   <= BCD_SHIFT;
               end
            end
            BCD_SHIFT: begin
               {bcd, bin_sr} <= {bcd_adj[10:0], bin_sr, 1'b0};
               if (bit_cnt == 3'd0)
                  state <= BCD_LOAD;
               else
                  bit_cnt <= bit_cnt - 3'd1;
            end
            BCD_LOAD: begin
               hex0  <= seg_of(bcd[3:0]);
               hex1  <= seg_of(bcd[7:4]);
               hex2  <= seg_of(bcd[11:8]);
               state <= BCD_IDLE;
            end
            default: state <= BCD_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/flappy_render.sv
// VGA timing, once-per-frame snapshot of the game state, object painter
// and score display for the flappy game.
module flappy_render
   import flappy_pkg::*;
#(
   parameter int H_ACT      = flappy_pkg::H_ACTIVE,
   parameter int H_FP       = flappy_pkg::H_FRONT,
   parameter int H_SW       = flappy_pkg::H_SYNC,
   parameter int H_BP       = flappy_pkg::H_BACK,
   parameter int V_ACT      = flappy_pkg::V_ACTIVE,
   parameter int V_FP       = flappy_pkg::V_FRONT,
   parameter int V_SW       = flappy_pkg::V_SYNC,
   parameter int V_BP       = flappy_pkg::V_BACK,
   parameter int BALL_COL   = flappy_pkg::BALL_X,
   parameter int PILLAR_GAP = flappy_pkg::PILLAR_HEIGHT
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] ball_y,
   input  logic [9:0] pillar_x,
   input  logic [9:0] pillar_y,
   input  logic [7:0] score,
   output logic       frame_tick,
   output logic       hsync,
   output logic       vsync,
   output logic       blank_n,
   output logic [7:0] vga_r,
   output logic [7:0] vga_g,
   output logic [7:0] vga_b,
   output logic [6:0] hex0,
   output logic [6:0] hex1,
   output logic [6:0] hex2
);

   localparam logic [9:0]  H_LAST  = 10'(H_ACT + H_FP + H_SW + H_BP - 1);
   localparam logic [9:0]  V_LAST  = 10'(V_ACT + V_FP + V_SW + V_BP - 1);
   localparam logic [9:0]  H_VIS   = 10'(H_ACT);
   localparam logic [9:0]  V_VIS   = 10'(V_ACT);
   localparam logic [9:0]  HS_ON   = 10'(H_ACT + H_FP);
   localparam logic [9:0]  HS_OFF  = 10'(H_ACT + H_FP + H_SW);
   localparam logic [9:0]  VS_ON   = 10'(V_ACT + V_FP);
   localparam logic [9:0]  VS_OFF  = 10'(V_ACT + V_FP + V_SW);
   localparam logic [10:0] BALL_L  = 11'(BALL_COL);
   localparam logic [10:0] BALL_R  = 11'(BALL_COL + BALL_WIDTH);
   localparam logic [10:0] BALL_H  = 11'(BALL_HEIGHT);
   localparam logic [10:0] PIL_W   = 11'(PILLAR_WIDTH);
   localparam logic [10:0] PIL_GAP = 11'(PILLAR_GAP);

   logic        pix_en;
   logic [9:0]  h_cnt, v_cnt;
   logic [9:0]  ball_y_sh, pillar_x_sh, pillar_y_sh;
   logic [7:0]  score_sh;
   logic        snap, visible, in_ball, in_pillar, bcd_busy;
   logic [10:0] x, y;
   logic [23:0] colour;

   assign snap = pix_en && (h_cnt == 10'd0) && (v_cnt == V_VIS);

   // 11-bit compares so object edges near the counter limit cannot wrap.
   always_comb begin
      x         = {1'b0, h_cnt};
      y         = {1'b0, v_cnt};
      visible   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
      in_ball   = (x >= BALL_L) && (x < BALL_R) &&
                  (y >= {1'b0, ball_y_sh}) && (y < ({1'b0, ball_y_sh} + BALL_H));
      in_pillar = (x >= {1'b0, pillar_x_sh}) && (x < ({1'b0, pillar_x_sh} + PIL_W)) &&
                  ((y < {1'b0, pillar_y_sh}) || (y >= ({1'b0, pillar_y_sh} + PIL_GAP)));
      if (in_ball)
         colour = COL_BALL;
      else if (in_pillar)
         colour = COL_PILLAR;
      else
         colour = COL_SKY;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pix_en      <= 1'b0;
         h_cnt       <= '0;
         v_cnt       <= '0;
         ball_y_sh   <= '0;
         pillar_x_sh <= '0;
         pillar_y_sh <= '0;
         score_sh    <= '0;
         frame_tick  <= 1'b0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         blank_n     <= 1'b0;
         {vga_r, vga_g, vga_b} <= '0;
      end else begin
         pix_en     <= ~pix_en;
         frame_tick <= snap;
         if (pix_en) begin
            if (h_cnt == H_LAST) begin
               h_cnt <= '0;
               v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
               h_cnt <= h_cnt + 10'd1;
            end
            hsync   <= ~((h_cnt >= HS_ON) && (h_cnt < HS_OFF));
            vsync   <= ~((v_cnt >= VS_ON) && (v_cnt < VS_OFF));
            blank_n <= visible;
            {vga_r, vga_g, vga_b} <= visible ? colour : 24'h000000;
         end
         if (snap) begin
            ball_y_sh   <= ball_y;
            pillar_x_sh <= pillar_x;
            pillar_y_sh <= pillar_y;
            score_sh    <= score;
         end
      end
   end

   // Conversion starts on frame_tick so the digits land exactly 10 clk later.
   seg7_bcd u_seg7_bcd (
      .clk   (clk),
      .reset (reset),
      .start (frame_tick & ~bcd_busy),
      .bin   (score_sh),
      .hex0  (hex0),
      .hex1  (hex1),
      .hex2  (hex2),
      .busy  (bcd_busy)
   );

endmodule
